uart_tx: RTL and testbench

Serial transmitter for the AXI4-Lite UART, mirroring the receive path. It buffers bytes written by the register block in an internal FIFO and serialises each byte onto `o_uart_tx` LSB-first as a frame:
- start bit;
- 5–8 data bits;
- optional parity bit;
- 1 or 2 stop bits.

Bit timing comes from the shared baud/strobe generator through the `o_tx_strb_en` / `i_tx_strb` handshake. FIFO level is reported to the interrupt logic through `o_threshold`.

---
 rtl/uart_tx.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter with TX FIFO, configurable framing and a
//               registered FIFO watermark flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_parity,
    input  logic [1:0] i_data_bits,
    input  logic       i_stop_bits,
    input  logic       i_use_parity,
    input  logic [2:0] i_threshold_value,
    output logic       o_threshold,
    input  logic       i_fifo_clear,
    input  logic       i_fifo_wr_en,
    input  logic [7:0] i_fifo_wr_data,
    output logic       o_fifo_full,
    output logic       o_fifo_empty,
    input  logic       i_tx_strb,
    output logic       o_tx_strb_en,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_overflow_error
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP0  = 3'd4,
        S_STOP1  = 3'd5
    } state_t;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;
    logic               r_overflow;
    logic [3:0]         r_watermark;
    logic               r_threshold;

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_parity_acc;
    logic [1:0] r_cfg_data_bits;
    logic       r_cfg_use_parity;
    logic       r_cfg_stop_bits;
    logic       r_tx;
    logic       r_strb_en;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [3:0] w_watermark;
    logic [2:0] w_last_idx;
    state_t     w_state_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic       w_parity_acc_nxt;
    logic       w_tx_nxt;

    assign w_full  = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    // Full is judged before any same-cycle pop, so a write while full is lost.
    assign w_push  = i_fifo_wr_en & ~w_full & ~i_fifo_clear;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_fifo_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (i_fifo_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_watermark = 4'd15;
        case (i_threshold_value)
            3'd0:    w_watermark = 4'd1;
            3'd1:    w_watermark = 4'd2;
            3'd2:    w_watermark = 4'd4;
            3'd3:    w_watermark = 4'd8;
            3'd4:    w_watermark = 4'd10;
            3'd5:    w_watermark = 4'd12;
            3'd6:    w_watermark = 4'd14;
            default: w_watermark = 4'd15;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_watermark <= 4'd1;
            r_threshold <= 1'b0;
        end else begin
            r_overflow  <= i_fifo_wr_en & w_full & ~i_fifo_clear;
            r_watermark <= w_watermark;
            r_threshold <= (32'(r_level) <= 32'(r_watermark));
        end
    end

    assign w_last_idx = 3'd4 + {1'b0, r_cfg_data_bits};

    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_parity_acc_nxt = r_parity_acc;
        w_tx_nxt         = r_tx;
        w_pop            = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty && !i_fifo_clear) begin
                    w_pop            = 1'b1;
                    w_shift_nxt      = r_mem[r_rd_ptr];
                    w_bit_cnt_nxt    = 3'd0;
                    w_parity_acc_nxt = i_parity;
                    w_tx_nxt         = 1'b0;
                    w_state_nxt      = S_START;
                end
            end
            S_START: begin
                if (i_tx_strb) begin
                    w_tx_nxt    = r_shift[0];
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (i_tx_strb) begin
                    w_parity_acc_nxt = r_parity_acc ^ r_shift[0];
                    if (r_bit_cnt != w_last_idx) begin
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end else if (r_cfg_use_parity) begin
                        w_tx_nxt    = r_parity_acc ^ r_shift[0];
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP0;
                    end
                end
            end
            S_PARITY: begin
                if (i_tx_strb) begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = S_STOP0;
                end
            end
            S_STOP0: begin
                w_tx_nxt = 1'b1;
                if (i_tx_strb) begin
                    w_state_nxt = r_cfg_stop_bits ? S_STOP1 : S_IDLE;
                end
            end
            S_STOP1: begin
                w_tx_nxt = 1'b1;
                if (i_tx_strb) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_shift          <= '0;
            r_bit_cnt        <= '0;
            r_parity_acc     <= 1'b0;
            r_cfg_data_bits  <= '0;
            r_cfg_use_parity <= 1'b0;
            r_cfg_stop_bits  <= 1'b0;
            r_tx             <= 1'b1;
            r_strb_en        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_parity_acc <= w_parity_acc_nxt;
            r_tx         <= w_tx_nxt;
            // Dropping the enable for the one idle cycle re-phases the generator.
            r_strb_en    <= (w_state_nxt != S_IDLE);
            if (w_pop) begin
                r_cfg_data_bits  <= i_data_bits;
                r_cfg_use_parity <= i_use_parity;
                r_cfg_stop_bits  <= i_stop_bits;
            end
        end
    end

    assign o_threshold      = r_threshold;
    assign o_fifo_full      = w_full;
    assign o_fifo_empty     = w_empty;
    assign o_tx_strb_en     = r_strb_en;
    assign o_uart_tx        = r_tx;
    assign o_busy           = (r_state != S_IDLE);
    assign o_overflow_error = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Directed self-checking bench for uart_tx; line bits are
//               checked against a queue of expected frame bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int PERIOD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_parity;
    logic [1:0] i_data_bits;
    logic       i_stop_bits;
    logic       i_use_parity;
    logic [2:0] i_threshold_value;
    logic       o_threshold;
    logic       i_fifo_clear;
    logic       i_fifo_wr_en;
    logic [7:0] i_fifo_wr_data;
    logic       o_fifo_full;
    logic       o_fifo_empty;
    logic       i_tx_strb;
    logic       o_tx_strb_en;
    logic       o_uart_tx;
    logic       o_busy;
    logic       o_overflow_error;

    uart_tx #(.FIFO_DEPTH(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_parity         (i_parity),
        .i_data_bits      (i_data_bits),
        .i_stop_bits      (i_stop_bits),
        .i_use_parity     (i_use_parity),
        .i_threshold_value(i_threshold_value),
        .o_threshold      (o_threshold),
        .i_fifo_clear     (i_fifo_clear),
        .i_fifo_wr_en     (i_fifo_wr_en),
        .i_fifo_wr_data   (i_fifo_wr_data),
        .o_fifo_full      (o_fifo_full),
        .o_fifo_empty     (o_fifo_empty),
        .i_tx_strb        (i_tx_strb),
        .o_tx_strb_en     (o_tx_strb_en),
        .o_uart_tx        (o_uart_tx),
        .o_busy           (o_busy),
        .o_overflow_error (o_overflow_error)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    logic q[$];
    int   strb_cnt = 0;
    bit   stall = 1'b0;
    logic prev_en = 1'b0;
    logic prev_strb = 1'b0;
    int   busy_cycles = 0;
    bit   in_gap = 1'b0;
    int   idle_run = 0;
    int   last_gap = -1;
    int   gap_line_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line bits listed in transmit order, first bit at the left.
    task automatic push_seq(input logic [15:0] seq, input int n);
        for (int i = 0; i < n; i++) q.push_back(seq[n-1-i]);
    endtask

    // One clock: scoreboard each new bit, then emulate the baud generator.
    task automatic cycle();
        logic exp_bit;
        @(posedge clk);
        #1;
        if (o_busy) busy_cycles++;
        if (o_tx_strb_en && (!prev_en || prev_strb)) begin
            exp_bit = (q.size() > 0) ? q.pop_front() : 1'bz;
            check("line_bit", 32'(o_uart_tx), 32'(exp_bit));
        end
        if (prev_en && !o_tx_strb_en) begin
            in_gap   = 1'b1;
            idle_run = 0;
        end
        if (in_gap) begin
            if (!o_tx_strb_en) begin
                idle_run++;
                if (o_uart_tx !== 1'b1) gap_line_bad++;
            end else begin
                last_gap = idle_run;
                in_gap   = 1'b0;
            end
        end
        if (o_tx_strb_en && !stall) begin
            strb_cnt++;
            if (strb_cnt == PERIOD) begin
                i_tx_strb = 1'b1;
                strb_cnt  = 0;
            end else begin
                i_tx_strb = 1'b0;
            end
        end else begin
            i_tx_strb = 1'b0;
            if (!o_tx_strb_en) strb_cnt = 0;
        end
        prev_en   = o_tx_strb_en;
        prev_strb = i_tx_strb;
    endtask

    task automatic write(input logic [7:0] d);
        i_fifo_wr_en   = 1'b1;
        i_fifo_wr_data = d;
        cycle();
        i_fifo_wr_en   = 1'b0;
    endtask

    task automatic play(input int budget);
        int n = 0;
        while ((q.size() > 0 || o_busy) && n < budget) begin
            cycle();
            n++;
        end
        check("play_drain", 32'(q.size()), 32'd0);
        check("play_idle_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic cfg(input logic [1:0] db, input logic up, input logic par, input logic sb);
        i_data_bits  = db;
        i_use_parity = up;
        i_parity     = par;
        i_stop_bits  = sb;
    endtask

    initial begin
        int tog;
        rst = 1'b1;
        i_threshold_value = 3'd0;
        i_fifo_clear = 1'b0;
        i_fifo_wr_en = 1'b0;
        i_fifo_wr_data = 8'h00;
        i_tx_strb = 1'b0;
        cfg(2'd3, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle();
        check("rst_tx", 32'(o_uart_tx), 32'd1);
        check("rst_strb_en", 32'(o_tx_strb_en), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_threshold", 32'(o_threshold), 32'd0);
        check("rst_overflow", 32'(o_overflow_error), 32'd0);
        check("rst_empty", 32'(o_fifo_empty), 32'd1);
        check("rst_full", 32'(o_fifo_full), 32'd0);
        rst = 1'b0;
        cycle();
        cycle();
        check("thr_after_rst", 32'(o_threshold), 32'd1);

        // 8N1 0xA5 with write-to-start latency and busy duration
        push_seq(16'b0101001011, 10);
        busy_cycles = 0;
        write(8'hA5);
        check("a5_empty_n1", 32'(o_fifo_empty), 32'd0);
        check("a5_busy_n1", 32'(o_busy), 32'd0);
        cycle();
        check("a5_busy_n2", 32'(o_busy), 32'd1);
        check("a5_tx_n2", 32'(o_uart_tx), 32'd0);
        check("a5_empty_n2", 32'(o_fifo_empty), 32'd1);
        play(400);
        check("a5_busy_cycles", 32'(busy_cycles), 32'd160);
        check("a5_idle_line", 32'(o_uart_tx), 32'd1);

        // 7E2 0x35
        cfg(2'd2, 1'b1, 1'b0, 1'b1);
        push_seq(16'b01010110011, 11);
        write(8'h35);
        play(400);

        // 5O1 0xFF, upper bits ignored
        cfg(2'd0, 1'b1, 1'b1, 1'b0);
        push_seq(16'b01111101, 8);
        write(8'hFF);
        play(400);

        // back-to-back frames separated by exactly one idle cycle
        cfg(2'd3, 1'b0, 1'b0, 1'b0);
        in_gap = 1'b0;
        last_gap = -1;
        gap_line_bad = 0;
        push_seq(16'b0101010101, 10);
        push_seq(16'b0010101011, 10);
        write(8'h55);
        write(8'hAA);
        play(800);
        check("b2b_gap", 32'(last_gap), 32'd1);
        check("b2b_gap_line", 32'(gap_line_bad), 32'd0);

        // overflow and clear with the strobe stalled mid-frame
        stall = 1'b1;
        push_seq(16'b0000000001, 10);
        write(8'h00);
        cycle();
        check("ovf_frame_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            write(8'(i + 1));
            if (i == 14) check("ovf_full_15", 32'(o_fifo_full), 32'd0);
        end
        check("ovf_full_16", 32'(o_fifo_full), 32'd1);
        check("ovf_none_yet", 32'(o_overflow_error), 32'd0);
        write(8'hEE);
        check("ovf_pulse", 32'(o_overflow_error), 32'd1);
        cycle();
        check("ovf_pulse_end", 32'(o_overflow_error), 32'd0);
        check("ovf_still_full", 32'(o_fifo_full), 32'd1);
        i_fifo_clear = 1'b1;
        i_fifo_wr_en = 1'b1;
        i_fifo_wr_data = 8'h77;
        cycle();
        i_fifo_clear = 1'b0;
        i_fifo_wr_en = 1'b0;
        check("clr_empty", 32'(o_fifo_empty), 32'd1);
        check("clr_full", 32'(o_fifo_full), 32'd0);
        check("clr_no_ovf", 32'(o_overflow_error), 32'd0);
        check("clr_frame_alive", 32'(o_busy), 32'd1);
        stall = 1'b0;
        play(400);

        // watermark 8 with one-cycle lag
        i_threshold_value = 3'd3;
        stall = 1'b1;
        push_seq(16'b0000000001, 10);
        write(8'h00);
        cycle();
        cycle();
        check("thr_lvl0", 32'(o_threshold), 32'd1);
        for (int lvl = 1; lvl <= 9; lvl++) begin
            write(8'(lvl));
            check("thr_lag", 32'(o_threshold), 32'((lvl - 1) <= 8));
            cycle();
            check("thr_level", 32'(o_threshold), 32'(lvl <= 8));
        end
        i_fifo_clear = 1'b1;
        cycle();
        i_fifo_clear = 1'b0;
        stall = 1'b0;
        play(400);
        i_threshold_value = 3'd0;

        // reset during DATA
        cfg(2'd3, 1'b0, 1'b0, 1'b0);
        push_seq(16'b0101001011, 10);
        write(8'hA5);
        repeat (PERIOD * 3 + 4) cycle();
        check("mid_busy", 32'(o_busy), 32'd1);
        write(8'h3C);
        check("mid_fifo_pending", 32'(o_fifo_empty), 32'd0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        q.delete();
        check("mid_rst_tx", 32'(o_uart_tx), 32'd1);
        check("mid_rst_empty", 32'(o_fifo_empty), 32'd1);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_strb_en", 32'(o_tx_strb_en), 32'd0);
        tog = 0;
        repeat (100) begin
            cycle();
            if (o_uart_tx !== 1'b1) tog++;
        end
        check("mid_rst_quiet", 32'(tog), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
